dm_ctrl: RTL and testbench
==========================

DM_CTRL -- requirements
Module: dm_ctrl

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset SHALL be asynchronous and active-low.
REQ-002 Parameter: TIMEOUT, default 15, max cycles waited for mem_ready before a bus error.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 req  in  1  CPU access request; sampled only in IDLE.
REQ-006 we  in  1  1 = store, 0 = load.
REQ-007 size  in  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-008 sign  in  1  load extension: 1 sign-extend, 0 zero-extend.
REQ-009 addr  in  32  byte address.
REQ-010 wdata  in  32  store data, right-justified.
REQ-011 rdata  out  32  extended load result.
REQ-012 done  out  1  one-cycle pulse on successful completion.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 err  out  2  one-cycle error code: 00 none, 01 misaligned/reserved size, 10 bus timeout.
REQ-015 mem_en  out  1  memory access strobe.
REQ-016 mem_be  out  4  byte enables (bit i = byte lane i, little-endian).
REQ-017 mem_we  out  1  memory write.
REQ-018 mem_addr  out  32  word address, {addr[31:2],2'b00}.
REQ-019 mem_wdata  out  32  lane-packed store data.
REQ-020 mem_rdata  in  32  memory read word.
REQ-021 mem_ready  in  1  memory completion; valid only while mem_en=1.

Function
REQ-022 FSM states SHALL be IDLE, ACCESS, DONE, ERR.
REQ-023 IDLE, req=1, legal alignment -> register we/size/sign/addr/wdata, go ACCESS; alignment legal = byte any, half addr[0]=0, word addr[1:0]=00.
REQ-024 IDLE, req=1, misaligned or size=11 -> ERR with err=01 next cycle; mem_en SHALL stay 0.
REQ-025 ACCESS: mem_en=1, mem_we=registered we, mem_be/mem_addr/mem_wdata from registered request, held stable until mem_ready.
REQ-026 Byte enables: byte 4'b0001<<addr[1:0]; half addr[1]?1100:0011; word 1111; mem_be SHALL be 0000 outside ACCESS.
REQ-027 Store packing: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-028 ACCESS, mem_ready=1 -> DONE; for loads rdata SHALL be loaded that edge.
REQ-029 Load extraction: byte mem_rdata[8*addr[1:0]+:8]; half addr[1]?[31:16]:[15:0]; extended to 32 bits per sign; word unchanged, sign ignored.
REQ-030 Stores and errored accesses SHALL NOT change rdata; rdata holds the last load result.
REQ-031 A wait counter SHALL clear on entering ACCESS and increment each ACCESS cycle with mem_ready=0; reaching TIMEOUT -> ERR with err=10, mem_en dropped.
REQ-032 DONE: done=1 for exactly one cycle, then IDLE; ERR: err nonzero for exactly one cycle, then IDLE.
REQ-033 Latency: with mem_ready on the first ACCESS cycle, done SHALL assert 2 cycles after the req-sampling edge.
REQ-034 req while busy=1 SHALL be ignored; a req held high through DONE/ERR SHALL be accepted again in the following IDLE cycle.
REQ-035 done and err SHALL never be asserted together.

Reset
REQ-036 rst_n=0 SHALL immediately force IDLE, rdata=0, done=0, busy=0, err=00, mem_en=0, mem_we=0, mem_be=0000, mem_addr=0, mem_wdata=0, counter=0, including mid-ACCESS.
REQ-037 After rst_n deassertion the first req SHALL be sampled on the next rising edge.

Verification
REQ-038 lb addr=0x1003, sign=1, mem_rdata=0x80FF_1234, ready immediate -> mem_be=1000, rdata=0xFFFF_FF80, done 2 cycles after req.
REQ-039 lhu addr=0x2002, mem_rdata=0x9ABC_5678 -> mem_be=1100, rdata=0x0000_9ABC.
REQ-040 sh addr=0x3002, wdata=0x1234_ABCD -> mem_we=1, mem_be=1100, mem_wdata=0xABCD_ABCD, mem_addr=0x3000, rdata unchanged.
REQ-041 lw addr=0x4001 -> err=01 one cycle, mem_en never asserted, no done.
REQ-042 lw addr=0x5000, mem_ready held 0 -> err=10 after TIMEOUT ACCESS cycles, mem_en low next cycle, block returns IDLE.
REQ-043 rst_n pulsed low mid-ACCESS -> all outputs zero asynchronously; no done or err afterwards.

Source files
------------

// File: rtl/dm_ctrl.sv
// CPU-side data memory controller: aligns byte/half/word loads and stores onto
// a 32-bit memory port, with misalignment detection and a bus-ready timeout.
module dm_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        busy,
    output logic [1:0]  err,
    output logic        mem_en,
    output logic [3:0]  mem_be,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;

    state_t         state_q, state_d;
    logic           we_q, we_d;
    logic [1:0]     size_q, size_d;
    logic           sign_q, sign_d;
    logic [31:0]    addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [31:0]    rdata_q, rdata_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     err_q, err_d;

    logic           legal;
    logic           in_acc;
    logic [3:0]     lane_be;
    logic [31:0]    lane_wdata;
    logic [31:0]    load_ext;
    logic [7:0]     byte_sel;
    logic [15:0]    half_sel;

    always_comb begin
        legal = 1'b0;
        case (size)
            2'b00:   legal = 1'b1;
            2'b01:   legal = ~addr[0];
            2'b10:   legal = (addr[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        lane_be    = 4'b1111;
        lane_wdata = wdata_q;
        case (size_q)
            2'b00: begin
                lane_be    = 4'b0001 << addr_q[1:0];
                lane_wdata = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                lane_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
                lane_be    = 4'b1111;
                lane_wdata = wdata_q;
            end
        endcase
    end

    assign byte_sel = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    assign half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        load_ext = mem_rdata;
        case (size_q)
            2'b00:   load_ext = {{24{sign_q & byte_sel[7]}}, byte_sel};
            2'b01:   load_ext = {{16{sign_q & half_sel[15]}}, half_sel};
            default: load_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        sign_d  = sign_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (req) begin
                    if (legal) begin
                        we_d    = we;
                        size_d  = size;
                        sign_d  = sign;
                        addr_d  = addr;
                        wdata_d = wdata;
                        state_d = ACCESS;
                    end else begin
                        err_d   = 2'b01;
                        state_d = ERR;
                    end
                end
            end
            ACCESS: begin
                // ready wins over timeout on the final allowed cycle
                if (mem_ready) begin
                    state_d = DONE;
                    if (!we_q) rdata_d = load_ext;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d   = 2'b10;
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: state_d = IDLE;
            ERR: begin
                err_d   = 2'b00;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            sign_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // memory port is driven only while accessing, so reset zeroes it at once
    assign in_acc    = (state_q == ACCESS);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign err       = (state_q == ERR) ? err_q : 2'b00;
    assign mem_en    = in_acc;
    assign mem_we    = in_acc & we_q;
    assign mem_be    = in_acc ? lane_be : 4'b0000;
    assign mem_addr  = in_acc ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem_wdata = in_acc ? lane_wdata : 32'h0;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_dm_ctrl.sv
// Directed bench for dm_ctrl: transaction tasks set per-cycle expectations
// from arithmetic rules; one compare process checks every cycle.
module tb_dm_ctrl;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0, we = 1'b0, sign = 1'b0, mem_ready = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] addr = 32'h0, wdata = 32'h0, mem_rdata = 32'h0;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic        done, busy, mem_en, mem_we;
    logic [1:0]  err;
    logic [3:0]  mem_be;

    dm_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .sign(sign),
        .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .busy(busy),
        .err(err), .mem_en(mem_en), .mem_be(mem_be), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic        chk_on = 1'b0, probe = 1'b0;
    logic        e_busy, e_done, e_en, e_we;
    logic [1:0]  e_err;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wdata, model_rdata;

    logic        pin_acc = 1'b0, pin_done = 1'b0;
    logic        pin_be_v = 1'b0, pin_wd_v = 1'b0, pin_rd_v = 1'b0, pin_ad_v = 1'b0;
    logic [3:0]  pin_be;
    logic [31:0] pin_wd, pin_rd, pin_ad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk or posedge probe) begin
        if (chk_on) begin
            chk("busy",      {31'b0, busy},   {31'b0, e_busy});
            chk("done",      {31'b0, done},   {31'b0, e_done});
            chk("err",       {30'b0, err},    {30'b0, e_err});
            chk("mem_en",    {31'b0, mem_en}, {31'b0, e_en});
            chk("mem_we",    {31'b0, mem_we}, {31'b0, e_we});
            chk("mem_be",    {28'b0, mem_be}, {28'b0, e_be});
            chk("mem_addr",  mem_addr,  e_addr);
            chk("mem_wdata", mem_wdata, e_wdata);
            chk("rdata",     rdata,     model_rdata);
            chk("done_err_excl", {31'b0, done & (err != 2'b00)}, 32'h0);
            if (pin_acc && pin_be_v) chk("pin_be",    {28'b0, mem_be}, {28'b0, pin_be});
            if (pin_acc && pin_wd_v) chk("pin_wdata", mem_wdata, pin_wd);
            if (pin_acc && pin_ad_v) chk("pin_addr",  mem_addr,  pin_ad);
            if (pin_done && pin_rd_v) chk("pin_rdata", rdata, pin_rd);
        end
    end

    function automatic bit legal(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'b11) return 1'b0;
        return (a % (32'd1 << sz)) == 0;
    endfunction

    function automatic logic [3:0] be_of(input logic [1:0] sz, input logic [31:0] a);
        int off;
        off = a % 4;
        if (sz == 2'b00) return 4'(1 << off);
        if (sz == 2'b01) return (off >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] pack(input logic [1:0] sz, input logic [31:0] wd);
        if (sz == 2'b00) return (wd % 256) * 32'h0101_0101;
        if (sz == 2'b01) return (wd % 65536) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] load_val(input logic [1:0] sz, input logic sg,
                                             input logic [31:0] a, input logic [31:0] m);
        longint v, full;
        int bits, off;
        bits = (sz == 2'b00) ? 8 : (sz == 2'b01) ? 16 : 32;
        off  = (sz == 2'b00) ? 8 * (a % 4) : (sz == 2'b01) ? 16 * ((a % 4) / 2) : 0;
        full = longint'(1) << bits;
        v = ({32'b0, m} >> off) % full;
        if (sg && bits < 32 && v >= full / 2) v = v - full;
        return v[31:0];
    endfunction

    task automatic set_idle();
        e_busy = 0; e_done = 0; e_err = 2'b00; e_en = 0; e_we = 0;
        e_be = 4'h0; e_addr = 32'h0; e_wdata = 32'h0;
    endtask

    task automatic set_acc(input logic w, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] wd);
        set_idle();
        e_busy = 1; e_en = 1; e_we = w;
        e_be = be_of(sz, a); e_addr = a - (a % 4); e_wdata = pack(sz, wd);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // waits >= TIMEOUT means mem_ready never rises
    task automatic xact(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] mr, input int waits);
        req = 1; we = w; size = sz; sign = sg; addr = a; wdata = wd;
        mem_rdata = mr; mem_ready = 0;
        set_idle();
        tick();
        req = 0;
        if (!legal(sz, a)) begin
            set_idle(); e_busy = 1; e_err = 2'b01;
            tick();
            set_idle();
            return;
        end
        for (int i = 0; i <= waits && i < TIMEOUT; i++) begin
            set_acc(w, sz, a, wd);
            pin_acc = 1;
            mem_ready = (i == waits);
            tick();
        end
        pin_acc = 0;
        mem_ready = 0;
        set_idle(); e_busy = 1;
        if (waits >= TIMEOUT) e_err = 2'b10;
        else begin
            e_done = 1;
            if (!w) model_rdata = load_val(sz, sg, a, mr);
            pin_done = 1;
        end
        tick();
        pin_done = 0;
        pin_be_v = 0; pin_wd_v = 0; pin_rd_v = 0; pin_ad_v = 0;
        set_idle();
    endtask

    initial begin
        set_idle();
        model_rdata = 32'h0;
        chk_on = 1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        tick();

        pin_be_v = 1; pin_be = 4'b1000; pin_rd_v = 1; pin_rd = 32'hFFFF_FF80;
        xact(0, 2'b00, 1, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0);
        pin_be_v = 1; pin_be = 4'b1100; pin_rd_v = 1; pin_rd = 32'h0000_9ABC;
        xact(0, 2'b01, 0, 32'h0000_2002, 32'h0, 32'h9ABC_5678, 0);
        pin_be_v = 1; pin_be = 4'b1100; pin_wd_v = 1; pin_wd = 32'hABCD_ABCD;
        pin_ad_v = 1; pin_ad = 32'h0000_3000; pin_rd_v = 1; pin_rd = 32'h0000_9ABC;
        xact(1, 2'b01, 0, 32'h0000_3002, 32'h1234_ABCD, 32'hDEAD_BEEF, 0);
        xact(0, 2'b10, 0, 32'h0000_4001, 32'h0, 32'h1111_1111, 0);
        xact(0, 2'b01, 1, 32'h0000_1001, 32'h0, 32'h1111_1111, 0);
        xact(0, 2'b11, 0, 32'h0000_0000, 32'h0, 32'h1111_1111, 0);
        xact(0, 2'b10, 0, 32'h0000_5000, 32'h0, 32'h2222_2222, TIMEOUT);
        tick();
        xact(0, 2'b00, 0, 32'h0000_1001, 32'h0, 32'h0000_A500, 3);
        xact(0, 2'b01, 1, 32'h0000_8000, 32'h0, 32'h0000_F00F, 1);
        xact(1, 2'b00, 0, 32'h0000_0001, 32'hFFFF_FF5A, 32'hCAFE_F00D, 2);
        xact(1, 2'b10, 0, 32'h0000_9004, 32'h0BAD_F00D, 32'h0, 0);
        xact(0, 2'b10, 1, 32'h0000_A008, 32'h0, 32'h8765_4321, TIMEOUT - 1);

        // req held high through ACCESS and DONE: ignored there, re-accepted in IDLE
        req = 1; we = 0; size = 2'b10; sign = 0; addr = 32'h0000_6000;
        mem_rdata = 32'h1122_3344; mem_ready = 0; set_idle();
        tick();
        set_acc(0, 2'b10, 32'h0000_6000, 32'h0); mem_ready = 1;
        tick();
        set_idle(); e_busy = 1; e_done = 1; model_rdata = 32'h1122_3344; mem_ready = 0;
        tick();
        set_idle(); addr = 32'h0000_6004; mem_rdata = 32'h5566_7788;
        tick();
        req = 0; set_acc(0, 2'b10, 32'h0000_6004, 32'h0); mem_ready = 1;
        tick();
        set_idle(); e_busy = 1; e_done = 1; model_rdata = 32'h5566_7788; mem_ready = 0;
        tick();
        set_idle();
        tick();

        // asynchronous reset in the middle of an access
        req = 1; we = 1; size = 2'b10; addr = 32'h0000_7000; wdata = 32'h7777_7777;
        mem_ready = 0; set_idle();
        tick();
        req = 0; set_acc(1, 2'b10, 32'h0000_7000, 32'h7777_7777);
        #1 rst_n = 0;
        #1 set_idle(); model_rdata = 32'h0; probe = 1;
        #1 probe = 0;
        mem_ready = 1;
        tick();
        rst_n = 1;
        mem_ready = 0;
        repeat (3) tick();

        chk_on = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
